// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM states,
// round-robin grant search and saturating addition.
package edge_evt_pkg;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  function automatic grant_t rr_next(input logic [MAX_CH-1:0] pend,
                                     input logic [IDX_W-1:0]  last,
                                     input int                n_ch);
    grant_t g;
    int     idx;
    g.found = 1'b0;
    g.idx   = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n_ch) begin
        idx = (int'(last) + k) % n_ch;
        if (pend[idx[IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = idx[IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rise_detect.sv
// Per-bit rising-edge detector; the previous-sample register updates every cycle.
module rise_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [W-1:0] strobe,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_strobe;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) prev_strobe <= '0;
    else       prev_strobe <= strobe;
  end

  assign rise = strobe & ~prev_strobe;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures strobe rising edges into per-channel pending flags and serves them
// round-robin on a single valid/ready port, counting lost events.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [N_CH-1:0]  strobe,
  input  logic             clr_drop,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic [N_CH-1:0]  pending,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   cap;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   drop;
  logic [MAX_CH-1:0] pend_ext;
  logic [31:0]       drop_sum;
  logic              accept;
  grant_t            grant;
  state_t            state;
  logic [CH_W-1:0]   last_grant;

  rise_detect #(.W(N_CH)) u_rise (
    .clk    (clk),
    .rstb   (rstb),
    .strobe (strobe),
    .rise   (rise)
  );

  assign accept = evt_valid & evt_ready;

  // A capture coinciding with its own channel's accept is a fresh event, not a drop.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign cap[gi]   = rise[gi] & en;
    assign clear[gi] = accept & (evt_ch == CH_W'(gi));
    assign drop[gi]  = cap[gi] & pending[gi] & ~clear[gi];
  end

  always_comb begin
    pend_ext              = '0;
    pend_ext[N_CH-1:0]    = pending;
    grant                 = rr_next(pend_ext, IDX_W'(last_grant), N_CH);
    drop_sum              = sat_add(32'(drop_cnt), 32'($countones(drop)), CNT_MAX);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= cap | (pending & ~clear);
      drop_cnt <= clr_drop ? '0 : CNT_W'(drop_sum);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant.found) begin
            evt_ch    <= CH_W'(grant.idx);
            evt_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            last_grant <= evt_ch;
            evt_valid  <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table, corner sequences and
// randomized traffic compared against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 2;
  localparam int CH_W    = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             en = 1'b0;
  logic [N_CH-1:0]  strobe = '0;
  logic             clr_drop = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [CH_W-1:0]  evt_ch;
  logic [N_CH-1:0]  pending;
  logic [CNT_W-1:0] drop_cnt;

  edge_event_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .strobe    (strobe),
    .clr_drop  (clr_drop),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event-level view of the channel queue.
  bit m_prev[N_CH];
  bit m_pend[N_CH];
  bit m_valid;
  int m_ch;
  int m_last;
  int m_drop;

  typedef struct {
    logic [N_CH-1:0] s;
    bit              en;
    bit              rdy;
    bit              clr;
    logic [N_CH-1:0] pend;
    bit              valid;
    int              ch;
    int              drop;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [N_CH-1:0] s, input bit e, input bit r, input bit c,
                   input logic [N_CH-1:0] p, input bit vl, input int ch, input int d);
    vec_t x;
    x.s = s; x.en = e; x.rdy = r; x.clr = c;
    x.pend = p; x.valid = vl; x.ch = ch; x.drop = d;
    tbl.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_prev[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_ch    = 0;
    m_last  = N_CH - 1;
    m_drop  = 0;
  endtask

  function automatic logic [N_CH-1:0] m_pend_vec();
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic model_step();
    bit acc;
    bit np[N_CH];
    int drops;
    if (!rstb) begin
      model_reset();
      return;
    end
    acc   = m_valid && evt_ready;
    drops = 0;
    for (int i = 0; i < N_CH; i++) begin
      bit cap_i, clr_i;
      cap_i = strobe[i] && !m_prev[i] && en;
      clr_i = acc && (m_ch == i);
      if (cap_i && m_pend[i] && !clr_i) drops++;
      np[i] = cap_i || (m_pend[i] && !clr_i);
    end
    if (clr_drop) m_drop = 0;
    else          m_drop = (m_drop + drops > CNT_MAX) ? CNT_MAX : m_drop + drops;
    if (m_valid) begin
      if (evt_ready) begin
        m_last  = m_ch;
        m_valid = 1'b0;
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (m_last + k) % N_CH;
        if (m_pend[c]) begin
          m_ch    = c;
          m_valid = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      m_prev[i] = strobe[i];
      m_pend[i] = np[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pending"}, 32'(pending), 32'(m_pend_vec()));
    check({tag, ".valid"}, 32'(evt_valid), 32'(m_valid));
    check({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    if (m_valid) check({tag, ".ch"}, 32'(evt_ch), 32'(m_ch));
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    strobe = '0; en = 1'b1; evt_ready = 1'b0; clr_drop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    int cnt;

    // Round-robin from reset (last_grant=3): order 0,1,2,3
    v(4'b1111,1,1,0, 4'b1111,0,0,0);
    v(4'b0000,1,1,0, 4'b1111,1,0,0);
    v(4'b0000,1,1,0, 4'b1110,0,0,0);
    v(4'b0000,1,1,0, 4'b1110,1,1,0);
    v(4'b0000,1,1,0, 4'b1100,0,0,0);
    v(4'b0000,1,1,0, 4'b1100,1,2,0);
    v(4'b0000,1,1,0, 4'b1000,0,0,0);
    v(4'b0000,1,1,0, 4'b1000,1,3,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    // Move last_grant to 1, then order 2,3,0,1
    v(4'b0010,1,1,0, 4'b0010,0,0,0);
    v(4'b0000,1,1,0, 4'b0010,1,1,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    v(4'b1111,1,1,0, 4'b1111,0,0,0);
    v(4'b0000,1,1,0, 4'b1111,1,2,0);
    v(4'b0000,1,1,0, 4'b1011,0,0,0);
    v(4'b0000,1,1,0, 4'b1011,1,3,0);
    v(4'b0000,1,1,0, 4'b0011,0,0,0);
    v(4'b0000,1,1,0, 4'b0011,1,0,0);
    v(4'b0000,1,1,0, 4'b0010,0,0,0);
    v(4'b0000,1,1,0, 4'b0010,1,1,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    // Single pulse latency on ch2
    v(4'b0100,1,0,0, 4'b0100,0,0,0);
    v(4'b0000,1,1,0, 4'b0100,1,2,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    // Drops on a stalled ch1, then clear
    v(4'b0010,1,0,0, 4'b0010,0,0,0);
    v(4'b0000,1,0,0, 4'b0010,1,1,0);
    v(4'b0010,1,0,0, 4'b0010,1,1,1);
    v(4'b0000,1,0,0, 4'b0010,1,1,1);
    v(4'b0010,1,0,0, 4'b0010,1,1,2);
    v(4'b0000,1,0,1, 4'b0010,1,1,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    // New rise on ch3 in its own accept cycle
    v(4'b1000,1,0,0, 4'b1000,0,0,0);
    v(4'b0000,1,0,0, 4'b1000,1,3,0);
    v(4'b1000,1,1,0, 4'b1000,0,0,0);
    v(4'b0000,1,0,0, 4'b1000,1,3,0);
    v(4'b0000,1,1,0, 4'b0000,0,0,0);
    // Five drops on ch0 saturate the 2-bit counter
    v(4'b0001,1,0,0, 4'b0001,0,0,0);
    v(4'b0000,1,0,0, 4'b0001,1,0,0);
    v(4'b0001,1,0,0, 4'b0001,1,0,1);
    v(4'b0000,1,0,0, 4'b0001,1,0,1);
    v(4'b0001,1,0,0, 4'b0001,1,0,2);
    v(4'b0000,1,0,0, 4'b0001,1,0,2);
    v(4'b0001,1,0,0, 4'b0001,1,0,3);
    v(4'b0000,1,0,0, 4'b0001,1,0,3);
    v(4'b0001,1,0,0, 4'b0001,1,0,3);
    v(4'b0000,1,0,0, 4'b0001,1,0,3);
    v(4'b0001,1,0,0, 4'b0001,1,0,3);
    v(4'b0000,1,1,1, 4'b0000,0,0,0);
    // Rise with en=0 is ignored
    v(4'b0100,0,0,0, 4'b0000,0,0,0);
    v(4'b0000,1,0,0, 4'b0000,0,0,0);
    // Two drops in one cycle
    v(4'b0011,1,0,0, 4'b0011,0,0,0);
    v(4'b0000,1,0,0, 4'b0011,1,1,0);
    v(4'b0011,1,0,0, 4'b0011,1,1,2);
    v(4'b0000,1,1,0, 4'b0001,0,0,2);
    v(4'b0000,1,0,0, 4'b0001,1,0,2);
    v(4'b0000,1,1,0, 4'b0000,0,0,2);

    // Reset state
    #2;
    check("reset.valid", 32'(evt_valid), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.drop", 32'(drop_cnt), 32'd0);
    do_reset();

    foreach (tbl[i]) begin
      strobe = tbl[i].s; en = tbl[i].en; evt_ready = tbl[i].rdy; clr_drop = tbl[i].clr;
      tick();
      check($sformatf("vec%0d.pending", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(tbl[i].valid));
      check($sformatf("vec%0d.drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
      if (tbl[i].valid) check($sformatf("vec%0d.ch", i), 32'(evt_ch), 32'(tbl[i].ch));
    end

    // Strobe held high across reset release gives exactly one event
    rstb = 1'b0;
    strobe = 4'b0001; en = 1'b1; evt_ready = 1'b1; clr_drop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_model($sformatf("held%0d", i));
      if (evt_valid) cnt++;
    end
    check("held.events", 32'(cnt), 32'd1);
    strobe = '0;
    tick();

    // Asynchronous reset mid-offer
    evt_ready = 1'b0;
    strobe = 4'b0010; tick();
    strobe = 4'b0000; tick();
    strobe = 4'b0010; tick();
    check_model("pre_areset");
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    check("areset.valid", 32'(evt_valid), 32'd0);
    check("areset.pending", 32'(pending), 32'd0);
    check("areset.drop", 32'(drop_cnt), 32'd0);
    strobe = '0;
    @(negedge clk);
    rstb = 1'b1;
    evt_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_valid) cnt++;
    end
    check("areset.spurious", 32'(cnt), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      strobe    = N_CH'($urandom);
      en        = ($urandom % 8) != 0;
      evt_ready = $urandom_range(0, 1) == 1;
      clr_drop  = ($urandom % 16) == 0;
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Collects rising-edge events from N_CH independent strobe inputs and queues one pending event per channel. Pending events are shared onto a single valid/ready event port using round-robin arbitration. Sits between raw strobe sources (buttons, sensor pulses) and one downstream consumer such as a UART reporter or LED controller. Lost events are counted in a saturating drop counter.

Parameters:
N_CH, 4, number of strobe channels (2..16)
CNT_W, 8, width of drop counter
CH_W, max(1,$clog2(N_CH)), channel index width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rstb  in  1  asynchronous active-low reset
en  in  1  capture enable; rises ignored when 0
strobe  in  N_CH  raw level inputs, already synchronous to clk
clr_drop  in  1  synchronous clear of drop_cnt
evt_valid  out  1  event offered to consumer
evt_ready  in  1  consumer accepts event
evt_ch  out  CH_W  channel index of offered event
pending  out  N_CH  per-channel pending flags
drop_cnt  out  CNT_W  saturating count of dropped events

Behaviour:
- Reset (rstb=0, async): prev_strobe=0, pending=0, drop_cnt=0, evt_valid=0, evt_ch=0, last_grant=N_CH-1, FSM=IDLE. Asserting reset mid-offer drops evt_valid immediately; the offered event is lost and not counted.
- Edge detect per channel (Mealy): rise[i] = strobe[i] & ~prev_strobe[i], combinational; prev_strobe[i] <= strobe[i] every cycle regardless of en. Because prev resets to 0, a strobe held high across reset release yields exactly one rise in the first cycle.
- Capture: cap[i] = rise[i] & en.
- pending[i] next state:
  - set if cap[i];
  - cleared if channel i completes handshake (evt_valid & evt_ready & evt_ch==i) and cap[i]=0;
  - if cap[i] and clear occur in the same cycle, pending[i] stays 1 (new event, not a drop).
- Drop: drop[i] = cap[i] & pending[i] & ~clear[i].
  - drop_cnt += popcount(drop), saturating at 2^CNT_W-1, no wrap.
  - clr_drop=1 forces drop_cnt to 0; drops in that same cycle are discarded.
- Arbiter FSM, 2 states:
  - IDLE: if |pending, choose the first set pending bit scanning last_grant+1, +2, ... modulo N_CH. Register evt_ch, set evt_valid=1, go to OFFER. Otherwise stay, evt_valid=0.
  - OFFER: evt_valid=1 and evt_ch held stable until evt_ready. On evt_valid&evt_ready: last_grant<=evt_ch, evt_valid<=0, go to IDLE.
  - Arbitration uses registered pending, so a capture in cycle t is eligible in cycle t+1.
- Latency: rise in cycle t -> pending visible t+1 -> evt_valid earliest t+2 (FSM in IDLE). Max throughput is one event per 2 cycles.
- en=0 never aborts an offer; already-pending events are still delivered.
- evt_ready while evt_valid=0 is ignored.
- evt_ch is valid only while evt_valid=1; it holds its last value otherwise.

Decomposition:
- Shared package edge_evt_pkg:
  - FSM state enum (ST_IDLE, ST_OFFER);
  - function rr_next(pending, last_grant) returning the grant index and a found flag;
  - saturating-add helper.
- Sub-module rise_detect: parameterised width W, clk/rstb/strobe in, rise out, with prev_strobe register. One instance is used with W=N_CH.

Test Plan:
1. Reset release with strobe=4'b0000, then pulse strobe[2] one cycle at t (en=1) -> pending=4'b0100 at t+1, evt_valid=1 with evt_ch=2 at t+2; ready=1 -> pending=0, evt_valid=0 next cycle.
2. Strobe rises on ch0..3 simultaneously, evt_ready held 1 -> grants in order 0,1,2,3, one every 2 cycles; repeat with last_grant=1 -> order 2,3,0,1.
3. Ch1 pending, evt_ready=0, two more rises on ch1 -> drop_cnt=2, pending[1] stays 1; then clr_drop pulse -> drop_cnt=0.
4. Ch3 offered, and in the accept cycle a new rise on ch3 -> pending[3] remains 1, drop_cnt unchanged, ch3 offered again 2 cycles later.
5. CNT_W=2, 5 drops -> drop_cnt saturates at 3. Strobe held high across reset release -> exactly one event. en=0 during a rise -> no pending, no drop.
6. Assert rstb low while evt_valid=1 -> evt_valid=0 asynchronously, pending=0, drop_cnt=0; after release, no spurious event.
